fp_vec_writer: RTL

FP_VEC_WRITER -- requirements
Module: fp_vec_writer

---
 rtl/fp_vec_writer_pkg.sv | 71 +++++++
 rtl/fp_vec_writer_if.sv | 33 +++
 rtl/fp_vec_fifo.sv | 58 +++++
 rtl/fp_vec_writer.sv | 94 +++++++++
 4 files changed

// File: rtl/fp_vec_writer_pkg.sv
// fp_wire: shared record layout for the FP vector writer (field positions, widths, packed types).
// Latency: n/a (types and a pure packing function only).
// Backpressure: n/a.
package fp_wire;

  localparam int DATA_W  = 64;
  localparam int FLAGS_W = 5;
  localparam int FMT_W   = 2;
  localparam int RM_W    = 3;
  localparam int CVT_W   = 2;
  localparam int OP_W    = 10;
  localparam int REC_W   = 288;

  // LSB of each record field; every bit not covered by a field is zero.
  localparam int REC_D1_LSB    = 224;
  localparam int REC_D2_LSB    = 160;
  localparam int REC_D3_LSB    = 96;
  localparam int REC_RES_LSB   = 32;
  localparam int REC_FLAGS_LSB = 24;
  localparam int REC_FMT_LSB   = 20;
  localparam int REC_RM_LSB    = 16;
  localparam int REC_CVT_LSB   = 12;
  localparam int REC_OP_LSB    = 0;

  // Issued operation waiting for its FPU completion.
  typedef struct packed {
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] data3;
    logic [FMT_W-1:0]  fmt;
    logic [RM_W-1:0]   rm;
    logic [CVT_W-1:0]  cvt_op;
    logic [OP_W-1:0]   opcode;
  } fp_vec_pend_type;

  // Output record; field order reproduces the bit positions listed above.
  typedef struct packed {
    logic [DATA_W-1:0]  data1;   // 287:224
    logic [DATA_W-1:0]  data2;   // 223:160
    logic [DATA_W-1:0]  data3;   // 159:96
    logic [DATA_W-1:0]  result;  // 95:32
    logic [2:0]         rsv0;    // 31:29
    logic [FLAGS_W-1:0] flags;   // 28:24
    logic [1:0]         rsv1;    // 23:22
    logic [FMT_W-1:0]   fmt;     // 21:20
    logic               rsv2;    // 19
    logic [RM_W-1:0]    rm;      // 18:16
    logic [1:0]         rsv3;    // 15:14
    logic [CVT_W-1:0]   cvt_op;  // 13:12
    logic [1:0]         rsv4;    // 11:10
    logic [OP_W-1:0]    opcode;  // 9:0
  } fp_vec_rec_type;

  function automatic fp_vec_rec_type pack_rec(input fp_vec_pend_type p,
                                              input logic [DATA_W-1:0] res,
                                              input logic [FLAGS_W-1:0] flags);
    fp_vec_rec_type r;
    r        = '0;
    r.data1  = p.data1;
    r.data2  = p.data2;
    r.data3  = p.data3;
    r.result = res;
    r.flags  = flags;
    r.fmt    = p.fmt;
    r.rm     = p.rm;
    r.cvt_op = p.cvt_op;
    r.opcode = p.opcode;
    return r;
  endfunction

endpackage

// File: rtl/fp_vec_writer_if.sv
// fp_vec_writer_if: issue, completion and record-stream signals of the FP vector writer.
// Latency: n/a (wiring only).
// Backpressure: rec stream is valid/ready; issue and completion have no backpressure.
interface fp_vec_writer_if;
  logic         issue_valid;
  logic [63:0]  issue_data1;
  logic [63:0]  issue_data2;
  logic [63:0]  issue_data3;
  logic [1:0]   issue_fmt;
  logic [2:0]   issue_rm;
  logic [1:0]   issue_cvt_op;
  logic [9:0]   issue_opcode;
  logic         res_ready;
  logic [63:0]  res_result;
  logic [4:0]   res_flags;
  logic         rec_valid;
  logic [287:0] rec_data;
  logic         rec_ready;

  modport master (
    output issue_valid, issue_data1, issue_data2, issue_data3,
           issue_fmt, issue_rm, issue_cvt_op, issue_opcode,
           res_ready, res_result, res_flags, rec_ready,
    input  rec_valid, rec_data
  );

  modport slave (
    input  issue_valid, issue_data1, issue_data2, issue_data3,
           issue_fmt, issue_rm, issue_cvt_op, issue_opcode,
           res_ready, res_result, res_flags, rec_ready,
    output rec_valid, rec_data
  );
endinterface

// File: rtl/fp_vec_fifo.sv
// fp_vec_fifo: generic synchronous FIFO; ports push_i/pop_i/wdata_i in, rdata_o/full_o/empty_o out.
// Latency: written word visible at rdata_o the cycle after push; rdata_o is the current head.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
module fp_vec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_eff, pop_eff;

  assign full_o   = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o  = (cnt_q == '0);
  assign pop_eff  = pop_i && !empty_o;
  // When full, a write lands in the slot being vacated by the same-cycle pop.
  assign push_eff = push_i && (!full_o || pop_eff);
  assign rdata_o  = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_eff) wptr_d = wptr_q + 1'b1;
    if (pop_eff)  rptr_d = rptr_q + 1'b1;
    if (push_eff && !pop_eff) cnt_d = cnt_q + 1'b1;
    if (pop_eff && !push_eff) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clock) begin
    if (push_eff) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/fp_vec_writer.sv
// fp_vec_writer: pairs FPU issues with completions into 288-bit records; ports: clock, reset, bus (slave), status flags, rec_count.
// Latency: record valid 1 cycle after the edge sampling res_ready (when output buffer was empty).
// Backpressure: rec_ready stalls the output buffer; overflowing issues/records are dropped and flagged sticky.
module fp_vec_writer
  import fp_wire::*;
#(
  parameter int PEND_DEPTH = 4,
  parameter int OUT_DEPTH  = 2
) (
  input  logic                clock,
  input  logic                reset,
  fp_vec_writer_if.slave      bus,
  output logic                issue_stall,
  output logic                overflow,
  output logic                orphan,
  output logic [31:0]         rec_count
);
  fp_vec_pend_type issue_ent, pend_head;
  fp_vec_rec_type  rec_new, out_head;
  logic            pend_full, pend_empty, out_full, out_empty;
  logic            compl, pend_push, out_push, xfer;
  logic            issue_drop, rec_drop, orphan_evt;
  logic            overflow_q, overflow_d;
  logic            orphan_q, orphan_d;
  logic [31:0]     rec_count_q, rec_count_d;

  assign issue_ent = '{data1:  bus.issue_data1,
                       data2:  bus.issue_data2,
                       data3:  bus.issue_data3,
                       fmt:    bus.issue_fmt,
                       rm:     bus.issue_rm,
                       cvt_op: bus.issue_cvt_op,
                       opcode: bus.issue_opcode};

  // Completion pairs only with an entry already pending; a same-cycle issue is never its partner.
  assign compl      = bus.res_ready && !pend_empty;
  assign orphan_evt = bus.res_ready && pend_empty;
  assign pend_push  = bus.issue_valid && (!pend_full || compl);
  assign issue_drop = bus.issue_valid && pend_full && !compl;

  assign xfer     = bus.rec_valid && bus.rec_ready;
  assign out_push = compl && (!out_full || xfer);
  assign rec_drop = compl && out_full && !xfer;
  assign rec_new  = pack_rec(pend_head, bus.res_result, bus.res_flags);

  fp_vec_fifo #(.WIDTH($bits(fp_vec_pend_type)), .DEPTH(PEND_DEPTH)) u_pend (
    .clock   (clock),
    .reset   (reset),
    .push_i  (pend_push),
    .pop_i   (compl),
    .wdata_i (issue_ent),
    .rdata_o (pend_head),
    .full_o  (pend_full),
    .empty_o (pend_empty)
  );

  fp_vec_fifo #(.WIDTH($bits(fp_vec_rec_type)), .DEPTH(OUT_DEPTH)) u_out (
    .clock   (clock),
    .reset   (reset),
    .push_i  (out_push),
    .pop_i   (xfer),
    .wdata_i (rec_new),
    .rdata_o (out_head),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

  // Head is masked when empty so rec_data reads zero out of reset and between records.
  assign bus.rec_valid = !out_empty;
  assign bus.rec_data  = out_empty ? '0 : out_head;

  always_comb begin
    overflow_d  = overflow_q | issue_drop | rec_drop;
    orphan_d    = orphan_q | orphan_evt;
    rec_count_d = rec_count_q + (xfer ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      orphan_q    <= 1'b0;
      rec_count_q <= '0;
    end else begin
      overflow_q  <= overflow_d;
      orphan_q    <= orphan_d;
      rec_count_q <= rec_count_d;
    end
  end

  assign issue_stall = pend_full;
  assign overflow    = overflow_q;
  assign orphan      = orphan_q;
  assign rec_count   = rec_count_q;
endmodule
